icache_refill: RTL and testbench
================================

# icache_refill

Instruction-cache line refill engine; the write-side master for the 1024x32 simple-dual-port instruction data RAM and its tag RAM. On a fetch miss it issues one burst read to external memory and writes each returned word into the data RAM at `{line_index, word_offset}`. It writes the tag and valid bit only after the whole line has landed, so the fetch/read side never hits on a partially filled line.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 10: data RAM word address width.
- `DATA_WIDTH`, 32: word width, in bits.
- `LINE_WORDS`, 8: words per line; must be a power of 2 and at least 2. `OFF_W = log2(LINE_WORDS)`.
- `MEM_ADDR_WIDTH`, 32: byte address width.
- `TAG_WIDTH`: derived, not overridable. Equals `MEM_ADDR_WIDTH - RAM_ADDR_WIDTH - 2`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_valid` in 1: miss request.
- `miss_ready` out 1: engine idle and accepting a miss.
- `miss_addr` in MEM_ADDR_WIDTH: byte address of the missing fetch.
- `mem_req_valid` out 1: burst read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out MEM_ADDR_WIDTH: line-aligned byte address.
- `mem_req_len` out 8: beats minus 1, constant `LINE_WORDS-1`.
- `mem_rvalid` in 1: read beat valid.
- `mem_rready` out 1: engine accepts beats.
- `mem_rdata` in DATA_WIDTH: read beat data.
- `mem_rlast` in 1: last beat marker.
- `ram_wr_en` out 1: data RAM write strobe.
- `ram_wr_addr` out RAM_ADDR_WIDTH: data RAM write address.
- `ram_wr_data` out DATA_WIDTH: data RAM write data.
- `tag_wr_en` out 1: tag RAM write strobe.
- `tag_wr_addr` out RAM_ADDR_WIDTH-OFF_W: line index.
- `tag_wr_data` out TAG_WIDTH+1: `{valid=1, tag}`.
- `refill_done` out 1: one-cycle pulse when the line is complete.
- `refill_err` out 1: one-cycle pulse on a protocol error.

## Operation
- States are IDLE, REQ, DATA, DONE. Reset enters IDLE.
- **IDLE**
  - `miss_ready=1`.
  - On `miss_valid`, latch `line_index = miss_addr[2+RAM_ADDR_WIDTH-1 : 2+OFF_W]` and `tag = miss_addr[MEM_ADDR_WIDTH-1 : 2+RAM_ADDR_WIDTH]`, clear `word_cnt`, then go to REQ.
- **REQ**
  - Outputs: `mem_req_valid=1`; `mem_req_addr = miss_addr` with its low `2+OFF_W` bits zeroed; `mem_req_len = LINE_WORDS-1`.
  - Address and length stay stable until `mem_req_ready`, then go to DATA.
- **DATA**
  - `mem_rready=1`.
  - Each accepted beat is registered: the next cycle drives `ram_wr_en=1`, `ram_wr_addr={line_index, word_cnt}`, `ram_wr_data=mem_rdata`. `word_cnt` then increments (OFF_W bits; it wraps only at end of line).
  - Beat with `word_cnt==LINE_WORDS-1` goes to DONE. If `mem_rlast` is 0 on that beat, also pulse `refill_err` (line still committed).
  - Beat with `mem_rlast=1` and `word_cnt<LINE_WORDS-1` is an early last. Write that beat, pulse `refill_err`, go to IDLE. No tag write; the line stays invalid.
- **DONE** (one cycle)
  - `tag_wr_en=1`, `tag_wr_addr=line_index`, `tag_wr_data={1'b1, tag}`, `refill_done=1`.
  - Goes to IDLE.
- `miss_valid` outside IDLE is ignored (`miss_ready=0`). `mem_rvalid` outside DATA is ignored (`mem_rready=0`).
- Reset asserted mid-refill:
  - All state returns to IDLE immediately; no further RAM or tag writes occur.
  - Data words already written remain, but the tag is never validated.

## Timing
- Reset values:
  - `miss_ready=1`.
  - All other outputs 0, except `mem_req_len`, which is the constant `LINE_WORDS-1`.
- Handshakes: `miss_valid`/`miss_ready` and `mem_req_valid`/`mem_req_ready` follow valid/ready rules. Transfer occurs on a clock edge where both are high. `mem_req_valid` never drops before `mem_req_ready`.
- Data RAM write lags beat acceptance by exactly 1 cycle. Beats may arrive back-to-back; every beat yields exactly one write.
- DONE (tag write, `refill_done`) falls in the same cycle as the last data RAM write.
- Because DONE shares that cycle, a reader issuing a read in the cycle after `refill_done` observes every word of the line (data RAM read latency is 1 cycle, no output register).
- `miss_ready` returns high the cycle after DONE. Minimum refill with zero wait states: accept, REQ 1 cycle, 8 beats, DONE = 11 cycles from miss acceptance to `miss_ready`.
- Any state except DATA may persist indefinitely while waiting on `miss_valid` or `mem_req_ready`. Gaps between beats are allowed.

## Test plan
- **Basic refill**
  - Stimulus: `miss_addr=0x0000_1234`, memory ready immediately, 8 back-to-back beats `0xA0..0xA7`, `rlast` on beat 7.
  - Required: `mem_req_addr=0x0000_1220`; RAM writes at addresses 0x088..0x08F with data 0xA0..0xA7; `tag_wr_addr=0x11`, `tag_wr_data={1,20'h00001}`; `refill_done` in the same cycle as the write to 0x08F.
- **Stalls**
  - Stimulus: `mem_req_ready` held low 5 cycles; beats separated by random 0–3 cycle gaps.
  - Required: request stays stable until accepted; exactly 8 writes; addresses contiguous.
- **Early rlast**
  - Stimulus: `rlast` on beat 3.
  - Required: 4 RAM writes, `refill_err` pulse, no `tag_wr_en`, `miss_ready=1` on the next cycle.
- **Missing rlast**
  - Stimulus: 8 beats with `rlast` never asserted.
  - Required: line committed (`tag_wr_en`, `refill_done`) and `refill_err` pulses once.
- **Reset mid-DATA**
  - Stimulus: assert `rst_n=0` after beat 2.
  - Required: all outputs at reset values within the same cycle; no tag write; a subsequent miss refills correctly.
- **Busy miss**
  - Stimulus: second `miss_valid` asserted during DATA.
  - Required: ignored until `miss_ready` rises; then accepted; the two refills do not overlap.

Source files
------------

// File: rtl/icache_refill_if.sv
// ---------------------------------------------------------------------------
// icache_refill_if
// Groups every bus that the instruction-cache refill engine talks on:
//   miss_*      : miss request from the fetch side (valid/ready + byte address)
//   mem_req_*   : burst read request to external memory (valid/ready + addr/len)
//   mem_r*      : read beats coming back from external memory
//   ram_wr_*    : write port of the instruction data RAM
//   tag_wr_*    : write port of the tag RAM ({valid, tag})
//   refill_done : one-cycle pulse when a line has been committed
//   refill_err  : one-cycle pulse on a burst protocol error
// The master modport is the refill engine; the slave modport is everything
// around it (fetch unit, memory, RAMs).
// ---------------------------------------------------------------------------
interface icache_refill_if #(
   parameter int RAM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_WORDS     = 8,
   parameter int MEM_ADDR_WIDTH = 32
) ();
   localparam int OFF_W     = $clog2(LINE_WORDS);
   localparam int TAG_WIDTH = MEM_ADDR_WIDTH - RAM_ADDR_WIDTH - 2;

   logic                             miss_valid;
   logic                             miss_ready;
   logic [MEM_ADDR_WIDTH-1:0]        miss_addr;

   logic                             mem_req_valid;
   logic                             mem_req_ready;
   logic [MEM_ADDR_WIDTH-1:0]        mem_req_addr;
   logic [7:0]                       mem_req_len;

   logic                             mem_rvalid;
   logic                             mem_rready;
   logic [DATA_WIDTH-1:0]            mem_rdata;
   logic                             mem_rlast;

   logic                             ram_wr_en;
   logic [RAM_ADDR_WIDTH-1:0]        ram_wr_addr;
   logic [DATA_WIDTH-1:0]            ram_wr_data;

   logic                             tag_wr_en;
   logic [RAM_ADDR_WIDTH-OFF_W-1:0]  tag_wr_addr;
   logic [TAG_WIDTH:0]               tag_wr_data;

   logic                             refill_done;
   logic                             refill_err;

   // Refill engine view
   modport master (
      input  miss_valid, miss_addr,
      output miss_ready,
      output mem_req_valid, mem_req_addr, mem_req_len,
      input  mem_req_ready,
      input  mem_rvalid, mem_rdata, mem_rlast,
      output mem_rready,
      output ram_wr_en, ram_wr_addr, ram_wr_data,
      output tag_wr_en, tag_wr_addr, tag_wr_data,
      output refill_done, refill_err
   );

   // Surrounding system view
   modport slave (
      output miss_valid, miss_addr,
      input  miss_ready,
      input  mem_req_valid, mem_req_addr, mem_req_len,
      output mem_req_ready,
      output mem_rvalid, mem_rdata, mem_rlast,
      input  mem_rready,
      input  ram_wr_en, ram_wr_addr, ram_wr_data,
      input  tag_wr_en, tag_wr_addr, tag_wr_data,
      input  refill_done, refill_err
   );
endinterface

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
// Instruction-cache line refill engine. On a fetch miss it issues a single
// burst read for the whole line, writes every returned word into the data RAM
// at {line_index, word_offset} one cycle after the beat is accepted, and only
// then writes {valid=1, tag} into the tag RAM, so the fetch side can never hit
// on a half-filled line.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : icache_refill_if.master (miss, memory request/read, RAM and tag
//           write ports, done/error pulses)
// ---------------------------------------------------------------------------
module icache_refill #(
   parameter int RAM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_WORDS     = 8,
   parameter int MEM_ADDR_WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   icache_refill_if.master bus
);
   localparam int OFF_W     = $clog2(LINE_WORDS);
   localparam int TAG_WIDTH = MEM_ADDR_WIDTH - RAM_ADDR_WIDTH - 2;
   localparam int IDX_W     = RAM_ADDR_WIDTH - OFF_W;

   // Clears the byte-in-word and word-in-line bits to form the burst address
   localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK = {MEM_ADDR_WIDTH{1'b1}} << (2 + OFF_W);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

   state_t                     r_state;
   logic [IDX_W-1:0]           r_lineIndex;
   logic [TAG_WIDTH-1:0]       r_tag;
   logic [OFF_W-1:0]           r_wordCnt;
   logic                       r_missReady;
   logic                       r_reqValid;
   logic [MEM_ADDR_WIDTH-1:0]  r_reqAddr;
   logic                       r_rReady;
   logic                       r_ramWrEn;
   logic [RAM_ADDR_WIDTH-1:0]  r_ramWrAddr;
   logic [DATA_WIDTH-1:0]      r_ramWrData;
   logic                       r_tagWrEn;
   logic [IDX_W-1:0]           r_tagWrAddr;
   logic [TAG_WIDTH:0]         r_tagWrData;
   logic                       r_done;
   logic                       r_err;

   logic                       w_beat;
   logic                       w_lastWord;

   // A beat transfers only while the engine advertises rready, which is
   // held high for exactly the DATA state.
   assign w_beat     = bus.mem_rvalid && r_rReady;
   assign w_lastWord = (r_wordCnt == OFF_W'(LINE_WORDS - 1));

   // Refill FSM. Every output is a register so the write strobes, the
   // tag commit and the done/error pulses all line up on the cycle after
   // the beat that caused them. The last data write and the tag write land
   // in the same cycle (the DONE state), which is what lets a reader issue
   // a read right after refill_done and see the whole line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_lineIndex <= '0;
         r_tag       <= '0;
         r_wordCnt   <= '0;
         r_missReady <= 1'b1;
         r_reqValid  <= 1'b0;
         r_reqAddr   <= '0;
         r_rReady    <= 1'b0;
         r_ramWrEn   <= 1'b0;
         r_ramWrAddr <= '0;
         r_ramWrData <= '0;
         r_tagWrEn   <= 1'b0;
         r_tagWrAddr <= '0;
         r_tagWrData <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ramWrEn <= 1'b0;
         r_tagWrEn <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.miss_valid) begin
                  r_lineIndex <= bus.miss_addr[2+RAM_ADDR_WIDTH-1 : 2+OFF_W];
                  r_tag       <= bus.miss_addr[MEM_ADDR_WIDTH-1 : 2+RAM_ADDR_WIDTH];
                  r_reqAddr   <= bus.miss_addr & ALIGN_MASK;
                  r_wordCnt   <= '0;
                  r_missReady <= 1'b0;
                  r_reqValid  <= 1'b1;
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  r_reqValid <= 1'b0;
                  r_rReady   <= 1'b1;
                  r_state    <= DATA;
               end
            end
            DATA: begin
               if (w_beat) begin
                  r_ramWrEn   <= 1'b1;
                  r_ramWrAddr <= {r_lineIndex, r_wordCnt};
                  r_ramWrData <= bus.mem_rdata;
                  r_wordCnt   <= r_wordCnt + OFF_W'(1);
                  if (w_lastWord) begin
                     // Full line landed: commit the tag even if rlast was
                     // missing, but flag the protocol slip.
                     r_rReady    <= 1'b0;
                     r_tagWrEn   <= 1'b1;
                     r_tagWrAddr <= r_lineIndex;
                     r_tagWrData <= {1'b1, r_tag};
                     r_done      <= 1'b1;
                     r_err       <= !bus.mem_rlast;
                     r_state     <= DONE;
                  end else if (bus.mem_rlast) begin
                     // Burst ended short: keep the words, never validate.
                     r_rReady    <= 1'b0;
                     r_err       <= 1'b1;
                     r_missReady <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
            end
            DONE: begin
               r_missReady <= 1'b1;
               r_state     <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.miss_ready    = r_missReady;
   assign bus.mem_req_valid = r_reqValid;
   assign bus.mem_req_addr  = r_reqAddr;
   assign bus.mem_req_len   = 8'(LINE_WORDS - 1);
   assign bus.mem_rready    = r_rReady;
   assign bus.ram_wr_en     = r_ramWrEn;
   assign bus.ram_wr_addr   = r_ramWrAddr;
   assign bus.ram_wr_data   = r_ramWrData;
   assign bus.tag_wr_en     = r_tagWrEn;
   assign bus.tag_wr_addr   = r_tagWrAddr;
   assign bus.tag_wr_data   = r_tagWrData;
   assign bus.refill_done   = r_done;
   assign bus.refill_err    = r_err;
endmodule

// File: tb/tb_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_icache_refill
// Self-checking bench for icache_refill. A memory/fetch driver plays one
// refill at a time; a monitor records every RAM write, tag write and pulse;
// a reference model computes from the address alone which words, addresses,
// tag and pulses each refill must produce.
// ---------------------------------------------------------------------------
module tb_icache_refill;
   localparam int RAM_AW    = 10;
   localparam int DW        = 32;
   localparam int LW        = 8;
   localparam int MAW       = 32;
   localparam int TAGW      = MAW - RAM_AW - 2;
   localparam int NUM_LINES = (1 << RAM_AW) / LW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   icache_refill_if #(.RAM_ADDR_WIDTH(RAM_AW), .DATA_WIDTH(DW),
                      .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)) bus ();

   icache_refill #(.RAM_ADDR_WIDTH(RAM_AW), .DATA_WIDTH(DW),
                   .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Free-running cycle stamp used to line up writes against the tag commit
   always @(posedge clk) cycle <= cycle + 1;

   // Everything the DUT writes, captured half a cycle after each edge
   logic [31:0] obsAddr[$];
   logic [31:0] obsData[$];
   int          obsCycle[$];
   int          tagCount, doneCount, errCount, tagCycle, doneCycle;
   logic [31:0] tagAddrSeen, tagDataSeen;
   logic [31:0] beatData[LW];

   // Monitor: log every write strobe and pulse while out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ram_wr_en) begin
            obsAddr.push_back(32'(bus.ram_wr_addr));
            obsData.push_back(32'(bus.ram_wr_data));
            obsCycle.push_back(cycle);
         end
         if (bus.tag_wr_en) begin
            tagCount++;
            tagAddrSeen = 32'(bus.tag_wr_addr);
            tagDataSeen = 32'(bus.tag_wr_data);
            tagCycle    = cycle;
         end
         if (bus.refill_done) begin
            doneCount++;
            doneCycle = cycle;
         end
         if (bus.refill_err) errCount++;
      end
   end

   // The one comparison point of the bench
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next falling edge (monitor has already run)
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string prefix);
      checkOutput({prefix, ".missReady"},  bus.miss_ready,    1);
      checkOutput({prefix, ".reqValid"},   bus.mem_req_valid, 0);
      checkOutput({prefix, ".reqAddr"},    bus.mem_req_addr,  0);
      checkOutput({prefix, ".reqLen"},     bus.mem_req_len,   LW - 1);
      checkOutput({prefix, ".rready"},     bus.mem_rready,    0);
      checkOutput({prefix, ".ramWrEn"},    bus.ram_wr_en,     0);
      checkOutput({prefix, ".ramWrAddr"},  bus.ram_wr_addr,   0);
      checkOutput({prefix, ".ramWrData"},  bus.ram_wr_data,   0);
      checkOutput({prefix, ".tagWrEn"},    bus.tag_wr_en,     0);
      checkOutput({prefix, ".tagWrAddr"},  bus.tag_wr_addr,   0);
      checkOutput({prefix, ".tagWrData"},  bus.tag_wr_data,   0);
      checkOutput({prefix, ".done"},       bus.refill_done,   0);
      checkOutput({prefix, ".err"},        bus.refill_err,    0);
   endtask

   // One complete refill: present the miss, play memory, then compare what
   // the monitor saw with what the reference model says must happen.
   //   lastBeat   : beat index carrying rlast (-1 = never)
   //   resetAfter : pull reset after this many accepted beats (0 = never)
   //   busy       : raise a second miss (busyAddr) mid-burst and leave it up
   task automatic applyStimulus(input logic [31:0] addr, input int reqStall,
                                input int maxGap, input int lastBeat,
                                input int resetAfter, input logic busy,
                                input logic [31:0] busyAddr, output int latency);
      logic [31:0] expLine, expTag, expReqAddr, expTagData;
      int          nBeats, expErr, waitCnt, beatsSent, acceptCycle, last;
      logic        full, stop;

      // Reference model: plain arithmetic on the byte address
      expLine    = (addr / (4 * LW)) % NUM_LINES;
      expTag     = addr / (32'd4 << RAM_AW);
      expReqAddr = addr - (addr % (4 * LW));
      expTagData = (32'd1 << TAGW) + expTag;
      if (resetAfter > 0) nBeats = resetAfter;
      else if (lastBeat >= 0 && lastBeat < LW - 1) nBeats = lastBeat + 1;
      else nBeats = LW;
      full   = (resetAfter <= 0) && (nBeats == LW);
      expErr = (resetAfter <= 0 && lastBeat != LW - 1) ? 1 : 0;

      obsAddr.delete();
      obsData.delete();
      obsCycle.delete();
      tagCount  = 0;
      doneCount = 0;
      errCount  = 0;

      waitCnt = 0;
      while (!bus.miss_ready && waitCnt < 100) begin
         step();
         waitCnt++;
      end
      checkOutput("missReadyIdle", bus.miss_ready, 1);
      bus.miss_valid = 1'b1;
      bus.miss_addr  = addr;
      acceptCycle    = cycle;
      step();
      bus.miss_valid = 1'b0;
      bus.miss_addr  = $urandom;

      checkOutput("reqValid",     bus.mem_req_valid, 1);
      checkOutput("reqAddr",      bus.mem_req_addr,  expReqAddr);
      checkOutput("reqLen",       bus.mem_req_len,   LW - 1);
      checkOutput("missReadyReq", bus.miss_ready,    0);
      for (int s = 0; s < reqStall; s++) begin
         step();
         checkOutput("reqHeldValid", bus.mem_req_valid, 1);
         checkOutput("reqHeldAddr",  bus.mem_req_addr,  expReqAddr);
      end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      checkOutput("reqDropped", bus.mem_req_valid, 0);

      beatsSent = 0;
      stop      = 1'b0;
      for (int b = 0; b < LW && !stop; b++) begin
         if (busy && b == 4) begin
            bus.miss_valid = 1'b1;
            bus.miss_addr  = busyAddr;
         end
         for (int g = int'($urandom_range(maxGap, 0)); g > 0; g--) step();
         waitCnt = 0;
         while (!bus.mem_rready && waitCnt < 20) begin
            step();
            waitCnt++;
         end
         if (!bus.mem_rready) begin
            checkOutput("rreadyTimeout", 0, 1);
            stop = 1'b1;
         end else begin
            checkOutput("missReadyData", bus.miss_ready,    0);
            checkOutput("reqIdleData",   bus.mem_req_valid, 0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beatData[b];
            bus.mem_rlast  = (b == lastBeat);
            step();
            bus.mem_rvalid = 1'b0;
            bus.mem_rlast  = 1'b0;
            bus.mem_rdata  = $urandom;
            beatsSent++;
            if (b == lastBeat && b < LW - 1) begin
               checkOutput("earlyLastReady", bus.miss_ready, 1);
               stop = 1'b1;
            end
            if (resetAfter > 0 && beatsSent == resetAfter) begin
               rst_n = 1'b0;
               #1;
               checkResetValues("midReset");
               step();
               step();
               rst_n = 1'b1;
               stop  = 1'b1;
            end
         end
      end

      waitCnt = 0;
      while (!bus.miss_ready && waitCnt < 20) begin
         step();
         waitCnt++;
      end
      checkOutput("missReadyReturn", bus.miss_ready, 1);
      latency = cycle - acceptCycle;

      checkOutput("wrCount", obsAddr.size(), nBeats);
      for (int i = 0; i < nBeats && i < obsAddr.size(); i++) begin
         checkOutput($sformatf("wrAddr[%0d]", i), obsAddr[i], expLine * LW + i);
         checkOutput($sformatf("wrData[%0d]", i), obsData[i], beatData[i]);
      end
      checkOutput("tagCount",  tagCount,  full ? 1 : 0);
      checkOutput("doneCount", doneCount, full ? 1 : 0);
      checkOutput("errCount",  errCount,  expErr);
      if (full && tagCount == 1 && obsAddr.size() > 0) begin
         last = obsCycle[obsAddr.size() - 1];
         checkOutput("tagAddr",      tagAddrSeen, expLine);
         checkOutput("tagData",      tagDataSeen, expTagData);
         checkOutput("tagWithLast",  tagCycle,    last);
         checkOutput("doneWithLast", doneCycle,   last);
      end
   endtask

   task automatic randomData();
      for (int i = 0; i < LW; i++) beatData[i] = $urandom;
   endtask

   initial begin
      int lat;
      bus.miss_valid    = 1'b0;
      bus.miss_addr     = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = '0;
      bus.mem_rlast     = 1'b0;
      rst_n             = 1'b0;
      repeat (3) step();
      checkResetValues("reset");
      rst_n = 1'b1;
      step();

      // Basic refill with fixed data and zero wait states
      for (int i = 0; i < LW; i++) beatData[i] = 32'hA0 + i;
      applyStimulus(32'h0000_1234, 0, 0, LW - 1, 0, 1'b0, 32'h0, lat);
      checkOutput("basicLatency",   lat,         11);
      checkOutput("basicFirstAddr", obsAddr.size() > 0 ? obsAddr[0] : 32'hFFFF_FFFF, 32'h088);
      checkOutput("basicLastAddr",  obsAddr.size() > 7 ? obsAddr[7] : 32'hFFFF_FFFF, 32'h08F);
      checkOutput("basicTagAddr",   tagAddrSeen, 32'h11);
      checkOutput("basicTagData",   tagDataSeen, 32'h0010_0001);

      // Request stall plus random gaps between beats
      randomData();
      applyStimulus($urandom, 5, 3, LW - 1, 0, 1'b0, 32'h0, lat);

      // Early rlast on beat 3
      randomData();
      applyStimulus($urandom, 1, 1, 3, 0, 1'b0, 32'h0, lat);

      // rlast never asserted
      randomData();
      applyStimulus($urandom, 0, 2, -1, 0, 1'b0, 32'h0, lat);

      // Reset after beats 0..2, then a clean refill
      randomData();
      applyStimulus($urandom, 0, 1, LW - 1, 3, 1'b0, 32'h0, lat);
      randomData();
      applyStimulus($urandom, 2, 2, LW - 1, 0, 1'b0, 32'h0, lat);

      // Second miss raised mid-burst; accepted only once idle again
      begin
         logic [31:0] second;
         second = $urandom;
         randomData();
         applyStimulus($urandom, 0, 1, LW - 1, 0, 1'b1, second, lat);
         randomData();
         applyStimulus(second, 0, 0, LW - 1, 0, 1'b0, 32'h0, lat);
      end

      // Random back-to-back refills
      for (int n = 0; n < 6; n++) begin
         randomData();
         applyStimulus($urandom, int'($urandom_range(4, 0)), 3, LW - 1, 0, 1'b0, 32'h0, lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop if something wedges beyond every bounded wait
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end
endmodule
